// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between NUM_MASTERS pipelined Wishbone masters, the arbiter and one slave.
// Modport master is the arbiter's view; modport slave is the view of the surrounding masters/slave.
interface wb_rr_arbiter_if #(
  parameter int NUM_MASTERS   = 2,
  parameter int WB_BUS_WIDTH  = 16,
  parameter int WB_ADDR_WIDTH = 32
);
  localparam int WB_SEL_WIDTH = WB_BUS_WIDTH / 8;

  logic [NUM_MASTERS-1:0]               m_cyc_i;
  logic [NUM_MASTERS-1:0]               m_stb_i;
  logic [NUM_MASTERS-1:0]               m_we_i;
  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0] m_addr_i;
  logic [NUM_MASTERS*WB_BUS_WIDTH-1:0]  m_data_i;
  logic [NUM_MASTERS*WB_SEL_WIDTH-1:0]  m_sel_i;
  logic [WB_BUS_WIDTH-1:0]              m_data_o;
  logic [NUM_MASTERS-1:0]               m_ack_o;
  logic [NUM_MASTERS-1:0]               m_err_o;
  logic [NUM_MASTERS-1:0]               m_rty_o;
  logic [NUM_MASTERS-1:0]               m_stall_o;

  logic                                 s_cyc_o;
  logic                                 s_stb_o;
  logic                                 s_we_o;
  logic [WB_ADDR_WIDTH-1:0]             s_addr_o;
  logic [WB_BUS_WIDTH-1:0]              s_data_o;
  logic [WB_SEL_WIDTH-1:0]              s_sel_o;
  logic [WB_BUS_WIDTH-1:0]              s_data_i;
  logic                                 s_ack_i;
  logic                                 s_err_i;
  logic                                 s_rty_i;
  logic                                 s_stall_i;

  modport master (
    input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, m_sel_i,
    output m_data_o, m_ack_o, m_err_o, m_rty_o, m_stall_o,
    output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, s_sel_o,
    input  s_data_i, s_ack_i, s_err_i, s_rty_i, s_stall_i
  );

  modport slave (
    output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, m_sel_i,
    input  m_data_o, m_ack_o, m_err_o, m_rty_o, m_stall_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, s_sel_o,
    output s_data_i, s_ack_i, s_err_i, s_rty_i, s_stall_i
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone pipelined arbiter: grant held for the owner's whole cyc, one idle cycle between owners.
// Optional watchdog enabled by defining WB_ARB_TIMEOUT_EN (limit TIMEOUT_CYCLES, 8-bit counter).
module wb_rr_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int WB_BUS_WIDTH   = 16,
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_reset_i,
  wb_rr_arbiter_if.master        bus,
  output logic [NUM_MASTERS-1:0] grant_o
);
  localparam int WB_SEL_WIDTH = WB_BUS_WIDTH / 8;
  localparam int IDX_W        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_params
    $error("wb_rr_arbiter: parameter out of range");
  end

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       owner;
  logic [IDX_W-1:0]       last;
  logic [IDX_W-1:0]       cand;
  logic [IDX_W-1:0]       next_owner;
  logic                   next_valid;
  logic [NUM_MASTERS-1:0] req;
  logic                   timeout;
  logic                   owned;

  assign owned = (state == GRANTED);

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0]             wd_cnt;
  logic [NUM_MASTERS-1:0] blocked;
  logic                   resp;

  assign resp    = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
  // A timed-out master stays masked until it lets go of cyc for a cycle.
  assign req     = bus.m_cyc_i & ~blocked;
  assign timeout = owned && bus.m_cyc_i[owner] && !resp &&
                   (wd_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      wd_cnt  <= '0;
      blocked <= '0;
    end else begin
      blocked <= blocked & bus.m_cyc_i;
      if (timeout) blocked[owner] <= 1'b1;
      if (!owned || resp) wd_cnt <= '0;
      else if (bus.m_cyc_i[owner]) wd_cnt <= wd_cnt + 8'd1;
    end
  end
`else
  assign req     = bus.m_cyc_i;
  assign timeout = 1'b0;
`endif

  // Search upward from last+1, wrapping, for the first active request.
  always_comb begin
    next_valid = 1'b0;
    next_owner = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      cand = IDX_W'((32'(last) + k) % NUM_MASTERS);
      if (!next_valid && req[cand]) begin
        next_valid = 1'b1;
        next_owner = cand;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      state   <= IDLE;
      owner   <= '0;
      last    <= IDX_W'(NUM_MASTERS - 1);
      grant_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (next_valid) begin
            state   <= GRANTED;
            owner   <= next_owner;
            grant_o <= NUM_MASTERS'(1) << next_owner;
          end
        end
        GRANTED: begin
          if (!bus.m_cyc_i[owner] || timeout) begin
            state   <= IDLE;
            last    <= owner;
            grant_o <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m_data_o = bus.s_data_i;

  always_comb begin
    bus.s_cyc_o   = 1'b0;
    bus.s_stb_o   = 1'b0;
    bus.s_we_o    = 1'b0;
    bus.s_addr_o  = '0;
    bus.s_data_o  = '0;
    bus.s_sel_o   = '0;
    bus.m_ack_o   = '0;
    bus.m_err_o   = '0;
    bus.m_rty_o   = '0;
    bus.m_stall_o = '1;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (owned && owner == IDX_W'(i)) begin
        bus.s_cyc_o      = bus.m_cyc_i[i] & ~timeout;
        bus.s_stb_o      = bus.m_stb_i[i] & ~timeout;
        bus.s_we_o       = bus.m_we_i[i];
        bus.s_addr_o     = bus.m_addr_i[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
        bus.s_data_o     = bus.m_data_i[i*WB_BUS_WIDTH +: WB_BUS_WIDTH];
        bus.s_sel_o      = bus.m_sel_i[i*WB_SEL_WIDTH +: WB_SEL_WIDTH];
        bus.m_ack_o[i]   = bus.s_ack_i;
        bus.m_err_o[i]   = bus.s_err_i | timeout;
        bus.m_rty_o[i]   = bus.s_rty_i;
        bus.m_stall_o[i] = bus.s_stall_i;
      end
    end
  end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter with three masters and an 8-cycle watchdog limit.
module tb_wb_rr_arbiter;
  localparam int NM = 3;
  localparam int DW = 16;
  localparam int AW = 32;

  logic          wb_clk_i = 1'b0;
  logic          wb_reset_i;
  logic [NM-1:0] grant_o;
  int            checks   = 0;
  int            failures = 0;

  wb_rr_arbiter_if #(.NUM_MASTERS(NM), .WB_BUS_WIDTH(DW), .WB_ADDR_WIDTH(AW)) bus ();

  wb_rr_arbiter #(
    .NUM_MASTERS(NM), .WB_BUS_WIDTH(DW), .WB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_reset_i (wb_reset_i),
    .bus        (bus),
    .grant_o    (grant_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    bus.m_cyc_i   = '0;
    bus.m_stb_i   = '0;
    bus.m_we_i    = '0;
    bus.m_addr_i  = '0;
    bus.m_data_i  = '0;
    bus.m_sel_i   = '0;
    bus.s_data_i  = '0;
    bus.s_ack_i   = 1'b0;
    bus.s_err_i   = 1'b0;
    bus.s_rty_i   = 1'b0;
    bus.s_stall_i = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    wb_reset_i = 1'b1;
    tick();
    tick();
    wb_reset_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (grant_o !== 3'b000) begin failures++; $display("FAIL reset_grant got=%b exp=000", grant_o); end
    checks++; if (bus.s_cyc_o !== 1'b0) begin failures++; $display("FAIL reset_scyc got=%b exp=0", bus.s_cyc_o); end
    checks++; if (bus.m_stall_o !== 3'b111) begin failures++; $display("FAIL reset_stall got=%b exp=111", bus.m_stall_o); end
    checks++; if ((bus.m_ack_o | bus.m_err_o | bus.m_rty_o) !== 3'b000) begin failures++; $display("FAIL reset_resp got=%b exp=000", bus.m_ack_o | bus.m_err_o | bus.m_rty_o); end
    checks++; if (bus.s_addr_o !== 32'h0) begin failures++; $display("FAIL reset_saddr got=%h exp=0", bus.s_addr_o); end
    bus.s_data_i = 16'hA5C3;
    #1;
    checks++; if (bus.m_data_o !== 16'hA5C3) begin failures++; $display("FAIL data_passthru got=%h exp=a5c3", bus.m_data_o); end
    bus.s_data_i = '0;
  endtask

  task automatic test_single_write();
    bus.m_cyc_i = 3'b001; bus.m_stb_i = 3'b001; bus.m_we_i = 3'b001;
    bus.m_addr_i[31:0] = 32'h10; bus.m_data_i[15:0] = 16'hBEEF; bus.m_sel_i[1:0] = 2'b11;
    #1;
    checks++; if (bus.s_cyc_o !== 1'b0) begin failures++; $display("FAIL sw_pre_scyc got=%b exp=0", bus.s_cyc_o); end
    tick();
    checks++; if (grant_o !== 3'b001) begin failures++; $display("FAIL sw_grant got=%b exp=001", grant_o); end
    checks++; if (bus.s_addr_o !== 32'h10) begin failures++; $display("FAIL sw_addr got=%h exp=10", bus.s_addr_o); end
    checks++; if ({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o} !== 3'b111) begin failures++; $display("FAIL sw_strobes got=%b exp=111", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}); end
    checks++; if (bus.s_data_o !== 16'hBEEF || bus.s_sel_o !== 2'b11) begin failures++; $display("FAIL sw_data got=%h/%b exp=beef/11", bus.s_data_o, bus.s_sel_o); end
    checks++; if (bus.m_stall_o !== 3'b110) begin failures++; $display("FAIL sw_stall got=%b exp=110", bus.m_stall_o); end
    tick();
    bus.m_stb_i = 3'b000;
    tick();
    bus.s_ack_i = 1'b1;
    #1;
    checks++; if (bus.m_ack_o !== 3'b001) begin failures++; $display("FAIL sw_ack got=%b exp=001", bus.m_ack_o); end
    checks++; if (bus.m_stall_o[1] !== 1'b1) begin failures++; $display("FAIL sw_stall1 got=%b exp=1", bus.m_stall_o[1]); end
    tick();
    bus.s_ack_i = 1'b0; bus.m_cyc_i = 3'b000; bus.m_we_i = 3'b000;
    #1;
    checks++; if (bus.s_cyc_o !== 1'b0) begin failures++; $display("FAIL sw_release_scyc got=%b exp=0", bus.s_cyc_o); end
    checks++; if (bus.m_ack_o !== 3'b000) begin failures++; $display("FAIL sw_ack_end got=%b exp=000", bus.m_ack_o); end
    tick();
    checks++; if (grant_o !== 3'b000) begin failures++; $display("FAIL sw_idle got=%b exp=000", grant_o); end
  endtask

  task automatic test_two_masters();
    do_reset();
    bus.m_cyc_i = 3'b011; bus.m_stb_i = 3'b011;
    bus.m_addr_i[31:0] = 32'h100; bus.m_addr_i[63:32] = 32'h200;
    tick();
    checks++; if (grant_o !== 3'b001) begin failures++; $display("FAIL two_grant0 got=%b exp=001", grant_o); end
    checks++; if (bus.s_addr_o !== 32'h100) begin failures++; $display("FAIL two_addr0 got=%h exp=100", bus.s_addr_o); end
    bus.s_ack_i = 1'b1;
    #1;
    checks++; if (bus.m_ack_o !== 3'b001) begin failures++; $display("FAIL two_ack0 got=%b exp=001", bus.m_ack_o); end
    tick();
    bus.s_ack_i = 1'b0; bus.m_cyc_i = 3'b010; bus.m_stb_i = 3'b010;
    #1;
    checks++; if (bus.s_cyc_o !== 1'b0) begin failures++; $display("FAIL two_release got=%b exp=0", bus.s_cyc_o); end
    tick();
    checks++; if (grant_o !== 3'b000) begin failures++; $display("FAIL two_gap got=%b exp=000", grant_o); end
    tick();
    checks++; if (grant_o !== 3'b010) begin failures++; $display("FAIL two_grant1 got=%b exp=010", grant_o); end
    checks++; if (bus.s_addr_o !== 32'h200) begin failures++; $display("FAIL two_addr1 got=%h exp=200", bus.s_addr_o); end
    bus.s_ack_i = 1'b1;
    #1;
    checks++; if (bus.m_ack_o !== 3'b010) begin failures++; $display("FAIL two_ack1 got=%b exp=010", bus.m_ack_o); end
    tick();
    clear_inputs();
    tick();
    checks++; if (grant_o !== 3'b000) begin failures++; $display("FAIL two_end got=%b exp=000", grant_o); end
  endtask

  task automatic test_round_robin();
    logic [NM-1:0] exp;
    do_reset();
    bus.m_cyc_i = 3'b111; bus.m_stb_i = 3'b111;
    for (int i = 0; i < NM; i++) bus.m_addr_i[i*AW +: AW] = 32'h1000 + 32'(i);
    tick();
    for (int k = 0; k < 6; k++) begin
      int g;
      g   = k % NM;
      exp = 3'(1 << g);
      checks++; if (grant_o !== exp) begin failures++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, grant_o, exp); end
      checks++; if (bus.s_addr_o !== 32'h1000 + 32'(g)) begin failures++; $display("FAIL rr_addr k=%0d got=%h exp=%h", k, bus.s_addr_o, 32'h1000 + 32'(g)); end
      bus.s_ack_i = 1'b1;
      #1;
      checks++; if (bus.m_ack_o !== exp) begin failures++; $display("FAIL rr_ack k=%0d got=%b exp=%b", k, bus.m_ack_o, exp); end
      tick();
      bus.s_ack_i = 1'b0; bus.m_cyc_i[g] = 1'b0; bus.m_stb_i[g] = 1'b0;
      tick();
      checks++; if (grant_o !== 3'b000) begin failures++; $display("FAIL rr_gap k=%0d got=%b exp=000", k, grant_o); end
      bus.m_cyc_i[g] = 1'b1; bus.m_stb_i[g] = 1'b1;
      tick();
    end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_pipelined_stall();
    int acks;
    do_reset();
    bus.m_cyc_i = 3'b011; bus.m_stb_i = 3'b001;
    bus.m_addr_i[31:0] = 32'h40;
    tick();
    bus.s_stall_i = 1'b1;
    #1;
    checks++; if (bus.m_stall_o !== 3'b111) begin failures++; $display("FAIL ps_stall got=%b exp=111", bus.m_stall_o); end
    checks++; if (bus.s_addr_o !== 32'h40) begin failures++; $display("FAIL ps_addr_s0 got=%h exp=40", bus.s_addr_o); end
    tick();
    checks++; if (bus.s_addr_o !== 32'h40) begin failures++; $display("FAIL ps_addr_s1 got=%h exp=40", bus.s_addr_o); end
    tick();
    bus.s_stall_i = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      bus.m_addr_i[31:0] = 32'h40 + 32'(4 * i);
      bus.s_ack_i = (i > 0);
      #1;
      checks++; if (bus.s_addr_o !== 32'h40 + 32'(4 * i)) begin failures++; $display("FAIL ps_addr i=%0d got=%h exp=%h", i, bus.s_addr_o, 32'h40 + 32'(4 * i)); end
      checks++; if (bus.m_ack_o !== ((i > 0) ? 3'b001 : 3'b000)) begin failures++; $display("FAIL ps_ack i=%0d got=%b exp=%b", i, bus.m_ack_o, (i > 0) ? 3'b001 : 3'b000); end
      if (bus.m_ack_o[0]) acks++;
      tick();
    end
    bus.m_stb_i = 3'b000; bus.s_ack_i = 1'b1;
    #1;
    checks++; if (bus.m_ack_o !== 3'b001) begin failures++; $display("FAIL ps_last_ack got=%b exp=001", bus.m_ack_o); end
    if (bus.m_ack_o[0]) acks++;
    tick();
    bus.s_ack_i = 1'b0;
    checks++; if (acks !== 4) begin failures++; $display("FAIL ps_ack_count got=%0d exp=4", acks); end
    checks++; if (grant_o !== 3'b001) begin failures++; $display("FAIL ps_no_preempt got=%b exp=001", grant_o); end
  endtask

  task automatic test_reset_mid();
    bus.m_cyc_i = 3'b010; bus.m_stb_i = 3'b000;
    tick();
    tick();
    checks++; if (grant_o !== 3'b010) begin failures++; $display("FAIL rm_grant1 got=%b exp=010", grant_o); end
    wb_reset_i = 1'b1;
    tick();
    checks++; if (grant_o !== 3'b000) begin failures++; $display("FAIL rm_grant got=%b exp=000", grant_o); end
    checks++; if (bus.s_cyc_o !== 1'b0) begin failures++; $display("FAIL rm_scyc got=%b exp=0", bus.s_cyc_o); end
    checks++; if (bus.m_stall_o !== 3'b111) begin failures++; $display("FAIL rm_stall got=%b exp=111", bus.m_stall_o); end
    wb_reset_i = 1'b0;
    bus.m_cyc_i = 3'b011; bus.m_stb_i = 3'b011;
    tick();
    checks++; if (grant_o !== 3'b001) begin failures++; $display("FAIL rm_rearb got=%b exp=001", grant_o); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_watchdog();
    do_reset();
    bus.m_cyc_i = 3'b011; bus.m_stb_i = 3'b001; bus.m_addr_i[31:0] = 32'h80;
    tick();
`ifdef WB_ARB_TIMEOUT_EN
    for (int c = 1; c < 8; c++) begin
      checks++; if (bus.m_err_o !== 3'b000 || bus.s_cyc_o !== 1'b1) begin failures++; $display("FAIL wd_early c=%0d got=%b/%b exp=000/1", c, bus.m_err_o, bus.s_cyc_o); end
      tick();
    end
    checks++; if (bus.m_err_o !== 3'b001) begin failures++; $display("FAIL wd_err got=%b exp=001", bus.m_err_o); end
    checks++; if (bus.s_cyc_o !== 1'b0) begin failures++; $display("FAIL wd_scyc got=%b exp=0", bus.s_cyc_o); end
    tick();
    checks++; if (grant_o !== 3'b000) begin failures++; $display("FAIL wd_idle got=%b exp=000", grant_o); end
    tick();
    checks++; if (grant_o !== 3'b010) begin failures++; $display("FAIL wd_next got=%b exp=010", grant_o); end
    bus.m_cyc_i[1] = 1'b0;
    tick();
    tick();
    checks++; if (grant_o !== 3'b000) begin failures++; $display("FAIL wd_lockout got=%b exp=000", grant_o); end
    bus.m_cyc_i[0] = 1'b0;
    tick();
    bus.m_cyc_i[0] = 1'b1;
    tick();
    checks++; if (grant_o !== 3'b001) begin failures++; $display("FAIL wd_regrant got=%b exp=001", grant_o); end
`else
    repeat (20) tick();
    checks++; if (grant_o !== 3'b001) begin failures++; $display("FAIL hold_grant got=%b exp=001", grant_o); end
    checks++; if (bus.m_err_o !== 3'b000 || bus.s_cyc_o !== 1'b1) begin failures++; $display("FAIL hold_bus got=%b/%b exp=000/1", bus.m_err_o, bus.s_cyc_o); end
`endif
    clear_inputs();
    tick();
    tick();
  endtask

  initial begin
    clear_inputs();
    wb_reset_i = 1'b1;
    test_reset();
    test_single_write();
    test_two_masters();
    test_round_robin();
    test_pipelined_stall();
    test_reset_mid();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end
endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin arbiter that lets `NUM_MASTERS` Wishbone pipelined masters (for example `wb_pipeline_master` instances) share one slave-side bus. It holds a grant for the whole of the owning master's bus cycle (`cyc` high). It muxes that master's request signals onto the slave bus and routes the slave responses back to the owner only; non-owners are stalled. It sits between the master instances and the slave interconnect, in the `wb_clk_i` domain.

## Interface
- `NUM_MASTERS`, 2: number of requesting masters; 2 to 8.
- `WB_BUS_WIDTH`, 16: data width.
- `WB_ADDR_WIDTH`, 32: address width.
- `WB_SEL_WIDTH`, `WB_BUS_WIDTH/8`: select width (localparam).
- `TIMEOUT_CYCLES`, 255: watchdog limit; used only with `WB_ARB_TIMEOUT_EN`; 8-bit counter.

- `wb_clk_i` in 1: clock; all logic runs on the rising edge.
- `wb_reset_i` in 1: synchronous, active-high reset.
- `m_cyc_i`, `m_stb_i`, `m_we_i` in `NUM_MASTERS` each: per-master request strobes; bit i belongs to master i.
- `m_addr_i` in `NUM_MASTERS*WB_ADDR_WIDTH`: flattened addresses; master i in slice [i*W +: W].
- `m_data_i` in `NUM_MASTERS*WB_BUS_WIDTH`: flattened write data.
- `m_sel_i` in `NUM_MASTERS*WB_SEL_WIDTH`: flattened byte selects.
- `m_data_o` out `WB_BUS_WIDTH`: slave read data, broadcast to all masters.
- `m_ack_o`, `m_err_o`, `m_rty_o`, `m_stall_o` out `NUM_MASTERS` each: per-master responses.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1 each: slave-side strobes.
- `s_addr_o` out `WB_ADDR_WIDTH`, `s_data_o` out `WB_BUS_WIDTH`, `s_sel_o` out `WB_SEL_WIDTH`: slave-side request fields.
- `s_data_i` in `WB_BUS_WIDTH`; `s_ack_i`, `s_err_i`, `s_rty_i`, `s_stall_i` in 1 each: slave responses.
- `grant_o` out `NUM_MASTERS`: one-hot current owner; all zero when idle.

## Operation
- State machine with two states.
  - IDLE: no owner. If any `m_cyc_i` bit is high, grant the first requester found searching upward from `last+1`, wrapping modulo `NUM_MASTERS`. Go to GRANTED.
  - GRANTED: owner g. Stay while `m_cyc_i[g]` is high. When it drops, go to IDLE and set `last <= g`.
- Reset sets state IDLE, `grant_o=0`, `last=NUM_MASTERS-1` so master 0 wins first.
- GRANTED routing:
  - `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_addr_o`, `s_data_o`, `s_sel_o` equal master g's signals, combinationally.
  - `m_ack_o[g]`, `m_err_o[g]`, `m_rty_o[g]`, `m_stall_o[g]` equal the corresponding `s_*_i` signals.
- Non-owners, and every master in IDLE: `m_stall_o` = 1; `m_ack_o`, `m_err_o`, `m_rty_o` = 0.
- IDLE slave outputs: `s_cyc_o`, `s_stb_o`, `s_we_o` = 0; address, data and sel = 0.
- `m_data_o` = `s_data_i` at all times.
- No preemption: a higher-index request waits until the current owner drops `cyc`.
- A new request arriving on the same cycle `cyc` drops does not change the IDLE-then-grant sequence.

## Timing
- Grant latency: `m_cyc_i` seen high in IDLE at edge N gives `grant_o` and `s_cyc_o` high after edge N. The first `stb` can reach the slave one cycle after the master raises `cyc`.
- The owner must hold `stb` while it sees stall, which is standard pipelined Wishbone.
- Release: owner drops `cyc` in cycle N. `s_cyc_o` goes low combinationally in cycle N, the state is IDLE after edge N, and the next owner is granted after edge N+1.
- There is exactly one idle cycle between owners.
- Responses pass through with zero latency; no response is ever routed to a non-owner.
- `wb_reset_i` asserted mid-cycle: after the edge, outputs take reset values. Outstanding slave acks are dropped, and the slave must itself be reset by the same signal.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on grant and on any `s_ack_i`, `s_err_i` or `s_rty_i`.
  - It increments each GRANTED cycle while `s_cyc_o` is high.
  - When it reaches `TIMEOUT_CYCLES`, for that cycle: `m_err_o[g]` = 1, `s_cyc_o` is forced to 0, and the state goes to IDLE with `last <= g`.
  - Master g is not re-granted while its `cyc` stays high, until it deasserts it for at least one cycle.
- `WB_ARB_TIMEOUT_EN` undefined: no counter or timeout logic is built; the grant is held indefinitely.

## Test plan
- Reset, then master 0 raises `cyc`/`stb` for a write to 0x10 and the slave acks after 2 cycles. Required: `grant_o`=01 one cycle later, `s_addr_o`=0x10, `m_ack_o`=01 pulse, `m_stall_o[1]`=1 throughout.
- Masters 0 and 1 raise `cyc` on the same cycle, each doing one transfer then dropping `cyc`. Required grant sequence: 01, idle 1 cycle, 10.
- Three masters request continuously, each cycle 1 transfer. Required grant order: 0,1,2,0,1,2 with exactly one idle cycle between grants.
- Owner issues 4 pipelined `stb` with `s_stall_i` high for 2 cycles. Required: address held on `s_addr_o` during stall, 4 acks delivered only to the owner.
- `wb_reset_i` pulsed while master 1 is granted. Required next cycle: `grant_o`=0, `s_cyc_o`=0, all `m_stall_o`=1; then master 0 wins the next arbitration.
- With `WB_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, the slave never acks. Required: `m_err_o[g]`=1 at the 8th cycle, then IDLE, and another requester is granted.
